svc_sram_rd_pipe: RTL and testbench

SVC_SRAM_RD_PIPE -- requirements
Module: svc_sram_rd_pipe

---
 rtl/svc_sram_rd_pipe.sv | 104 ++++++++++
 tb/tb_svc_sram_rd_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_sram_rd_pipe.sv
// Read pipeline for a fixed-latency synchronous SRAM: issues reads, tracks tags
// alongside the data and buffers responses in a credit-protected FIFO.
module svc_sram_rd_pipe #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int META_WIDTH   = 4,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sram_rd_cmd_valid,
  output logic                  sram_rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] sram_rd_cmd_addr,
  input  logic [META_WIDTH-1:0] sram_rd_cmd_meta,
  input  logic                  sram_rd_cmd_last,
  output logic                  sram_rd_resp_valid,
  input  logic                  sram_rd_resp_ready,
  output logic [DATA_WIDTH-1:0] sram_rd_resp_data,
  output logic [META_WIDTH-1:0] sram_rd_resp_meta,
  output logic                  sram_rd_resp_last,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                    accept;
  logic                    pop;
  logic                    land;
  logic [CNT_W-1:0]        out_cnt;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [META_WIDTH-1:0]   pipe_meta [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [META_WIDTH-1:0]   fifo_meta [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];

  // Credits cover both in-flight tags and buffered entries, so a landing read always has room.
  assign sram_rd_cmd_ready  = !rst && (out_cnt < CNT_W'(FIFO_DEPTH));
  assign accept             = sram_rd_cmd_valid && sram_rd_cmd_ready;
  assign mem_rd_en          = accept;
  assign mem_rd_addr        = sram_rd_cmd_addr;
  assign land               = pipe_valid[READ_LATENCY-1];
  assign sram_rd_resp_valid = !rst && (fifo_cnt != '0);
  assign pop                = sram_rd_resp_valid && sram_rd_resp_ready;
  assign sram_rd_resp_data  = fifo_data[rd_ptr];
  assign sram_rd_resp_meta  = fifo_meta[rd_ptr];
  assign sram_rd_resp_last  = fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_meta[0] <= sram_rd_cmd_meta;
    pipe_last[0] <= sram_rd_cmd_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_meta[i] <= pipe_meta[i-1];
      pipe_last[i] <= pipe_last[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (land) begin
      fifo_data[wr_ptr] <= mem_rd_data;
      fifo_meta[wr_ptr] <= pipe_meta[READ_LATENCY-1];
      fifo_last[wr_ptr] <= pipe_last[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_cnt  <= '0;
    end else begin
      if (land) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({land, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_svc_sram_rd_pipe.sv
// Scoreboard bench for svc_sram_rd_pipe: default instance under directed and random
// traffic, plus READ_LATENCY 1 and 8 instances with a 16-deep FIFO for streaming.
module tb_svc_sram_rd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_last;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_meta;
  logic        resp_valid, resp_ready, resp_last;
  logic [15:0] resp_data;
  logic [3:0]  resp_meta;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr, mem_rd_data;
  logic [15:0] mem_q [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [20:0] sb [$];
  bit sweep_done [2];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a * 16'd499) ^ 16'h5A5A;
  endfunction

  svc_sram_rd_pipe u_dut (
    .clk(clk), .rst(rst),
    .sram_rd_cmd_valid(cmd_valid), .sram_rd_cmd_ready(cmd_ready),
    .sram_rd_cmd_addr(cmd_addr), .sram_rd_cmd_meta(cmd_meta), .sram_rd_cmd_last(cmd_last),
    .sram_rd_resp_valid(resp_valid), .sram_rd_resp_ready(resp_ready),
    .sram_rd_resp_data(resp_data), .sram_rd_resp_meta(resp_meta), .sram_rd_resp_last(resp_last),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  // Two-cycle synchronous memory; garbage when not enabled so stray samples show up.
  always @(posedge clk) begin
    mem_q[0] <= mem_rd_en ? mem_fn(mem_rd_addr) : 16'hDEAD;
    mem_q[1] <= mem_q[0];
  end
  assign mem_rd_data = mem_q[1];

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        chk("mem_rd_en", mem_rd_en, 1);
        chk("mem_rd_addr", mem_rd_addr, cmd_addr);
        sb.push_back({mem_fn(cmd_addr), cmd_meta, cmd_last});
      end else begin
        chk("mem_rd_en_idle", mem_rd_en, 0);
      end
      if (resp_valid) begin
        if (sb.size() == 0) chk("resp_extra", resp_valid, 0);
        else begin
          chk("resp_head", {resp_data, resp_meta, resp_last}, sb[0]);
          if (resp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    resp_ready = 1'b1;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, stale, drops;
    rst = 1'b1; cmd_valid = 1'b1; cmd_addr = '0; cmd_meta = '0; cmd_last = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    @(posedge clk); #1 rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);

    // single read
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_addr = 16'h0010; cmd_meta = 4'd3; cmd_last = 1'b1;
    @(negedge clk);
    chk("single_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("single_latency", n, 3);
    chk("single_resp", {resp_data, resp_meta, resp_last}, {16'hBEEF, 4'd3, 1'b1});
    wait_drain("single_drain");

    // 8-beat burst at full rate
    drops = 0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      cmd_valid = 1'b1; cmd_addr = 16'(k); cmd_meta = 4'(k); cmd_last = (k == 7);
      @(negedge clk);
      if (!cmd_ready) drops++;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("burst_ready_drops", drops, 0);
    wait_drain("burst_drain");

    // backpressure fills credits
    resp_ready = 1'b0; n = 0;
    for (int k = 0; k < 10; k++) begin
      cmd_valid = 1'b1; cmd_addr = 16'(16'h0100 + k); cmd_meta = 4'(k); cmd_last = k[0];
      @(negedge clk);
      if (cmd_ready) n++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", n, 4);
    chk("bp_resp_valid", resp_valid, 1);
    cmd_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_full", cmd_ready, 0);
    @(negedge clk);
    chk("bp_ready_after_pop", cmd_ready, 1);
    @(posedge clk); #1;
    wait_drain("bp_drain");

    // accept and pop together right at the credit limit
    resp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1; cmd_addr = 16'(16'h0200 + k); cmd_meta = 4'(k); cmd_last = 1'b0;
      @(posedge clk); #1;
    end
    n = 0;
    for (int k = 0; k < 12; k++) begin
      cmd_valid = 1'b1; resp_ready = 1'b1;
      cmd_addr = 16'(16'h0300 + k); cmd_meta = 4'(k); cmd_last = (k == 11);
      @(negedge clk);
      if (cmd_ready) n++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("edge_ready_cycles", n, 11);
    wait_drain("edge_drain");

    // random valid/ready
    n = 0;
    for (int c = 0; c < 8000 && n < 1000; c++) begin
      cmd_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      cmd_addr = 16'($urandom); cmd_meta = 4'($urandom); cmd_last = 1'($urandom);
      @(negedge clk);
      if (cmd_valid && cmd_ready) n++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("rand_accepts", n, 1000);
    wait_drain("rand_drain");

    // reset with three reads outstanding
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_addr = 16'(16'h0400 + k); cmd_meta = 4'(k); cmd_last = 1'b0;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1 rst = 1'b0; resp_ready = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) stale++;
    end
    chk("midrst_stale", stale, 0);
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_addr = 16'h0042; cmd_meta = 4'd9; cmd_last = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_drain("midrst_drain");

    n = 0;
    while (!(sweep_done[0] && sweep_done[1]) && n < 500) begin @(posedge clk); n++; end
    chk("sweep_done", {sweep_done[0], sweep_done[1]}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int LAT = (g == 0) ? 1 : 8;
    logic        rst_s, cv, cr, cl, rv, rr, rl, me;
    logic [15:0] ca, ma, md, rd;
    logic [3:0]  cm, rm;
    logic [15:0] mpipe [LAT];

    svc_sram_rd_pipe #(.READ_LATENCY(LAT), .FIFO_DEPTH(16)) u_dut (
      .clk(clk), .rst(rst_s),
      .sram_rd_cmd_valid(cv), .sram_rd_cmd_ready(cr),
      .sram_rd_cmd_addr(ca), .sram_rd_cmd_meta(cm), .sram_rd_cmd_last(cl),
      .sram_rd_resp_valid(rv), .sram_rd_resp_ready(rr),
      .sram_rd_resp_data(rd), .sram_rd_resp_meta(rm), .sram_rd_resp_last(rl),
      .mem_rd_en(me), .mem_rd_addr(ma), .mem_rd_data(md)
    );

    always @(posedge clk) begin
      mpipe[0] <= me ? mem_fn(ma) : 16'hDEAD;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign md = mpipe[LAT-1];

    initial begin
      logic [20:0] q [$];
      logic [20:0] e;
      int acc0, rsp0, rsp_last, n_rsp, drops;
      rst_s = 1'b1; cv = 1'b0; rr = 1'b1; ca = '0; cm = '0; cl = 1'b0;
      acc0 = -1; rsp0 = -1; rsp_last = -1; n_rsp = 0; drops = 0;
      repeat (3) @(posedge clk);
      #1 rst_s = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (k < 20) begin
          cv = 1'b1; ca = 16'(k * 3); cm = 4'(k); cl = (k == 19);
        end else cv = 1'b0;
        @(negedge clk);
        if (cv && cr) begin
          q.push_back({mem_fn(ca), cm, cl});
          if (acc0 < 0) acc0 = k;
        end else if (cv) drops++;
        if (rv) begin
          if (rsp0 < 0) rsp0 = k;
          rsp_last = k; n_rsp++;
          if (q.size() == 0) chk($sformatf("sweep%0d_extra", LAT), rv, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("sweep%0d_resp", LAT), {rd, rm, rl}, e);
          end
        end
        @(posedge clk); #1;
      end
      chk($sformatf("sweep%0d_latency", LAT), rsp0 - acc0, LAT + 1);
      chk($sformatf("sweep%0d_ready_drops", LAT), drops, 0);
      chk($sformatf("sweep%0d_count", LAT), n_rsp, 20);
      chk($sformatf("sweep%0d_stream_span", LAT), rsp_last - rsp0, 19);
      sweep_done[g] = 1'b1;
    end
  end

endmodule
